mips_result_uart: RTL and testbench

- Downstream consumer of the 16-bit processor's architectural outputs (PC, R1, R2, R3).
- Watches PC for a programmed halt address and snapshots R1/R2/R3 on the first cycle it is reached.
- Serialises the snapshot as seven 8N1 UART bytes: six data bytes plus an XOR checksum.
- Sits between the processor top level and the board TX pin, so a multiply program's result can be read on a host terminal.

---
 rtl/mips_result_uart.sv | 138 +++++++++++++
 tb/tb_mips_result_uart.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_result_uart.sv
// Watches the processor PC for a halt address, snapshots R1/R2/R3 and sends them
// as seven 8N1 UART bytes (six data bytes plus an XOR checksum).
module mips_result_uart #(
  parameter int unsigned     CLKS_PER_BIT = 868,
  parameter int unsigned     PC_W         = 6,
  parameter logic [PC_W-1:0] DONE_PC      = PC_W'(63)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] PC,
  input  logic [15:0]     R1,
  input  logic [15:0]     R2,
  input  logic [15:0]     R3,
  output logic            tx,
  output logic            busy,
  output logic            done
);

  localparam int unsigned CNT_W = 12;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic             armed;
  logic [CNT_W-1:0] baud;
  logic [2:0]       bit_idx;
  logic [2:0]       byte_idx;
  logic [15:0]      snap_r1;
  logic [15:0]      snap_r2;
  logic [15:0]      snap_r3;
  logic [7:0]       ck;
  logic [7:0]       cur_byte;
  logic [2:0]       bit_nxt;
  logic             bit_end;
  logic             trigger;

  assign bit_end = (baud == CNT_W'(CLKS_PER_BIT - 1));
  assign bit_nxt = bit_idx + 3'd1;
  assign trigger = (state == IDLE) && armed && (PC == DONE_PC);

  // Byte currently on the wire; byte 6 is the running checksum of bytes 0..5.
  always_comb begin
    cur_byte = ck;
    case (byte_idx)
      3'd0:    cur_byte = snap_r1[15:8];
      3'd1:    cur_byte = snap_r1[7:0];
      3'd2:    cur_byte = snap_r2[15:8];
      3'd3:    cur_byte = snap_r2[7:0];
      3'd4:    cur_byte = snap_r3[15:8];
      3'd5:    cur_byte = snap_r3[7:0];
      default: cur_byte = ck;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      armed    <= 1'b1;
      baud     <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      snap_r1  <= '0;
      snap_r2  <= '0;
      snap_r3  <= '0;
      ck       <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;

      // Leaving the halt address re-arms, even mid-report.
      if (PC != DONE_PC) begin
        armed <= 1'b1;
      end else if (trigger) begin
        armed <= 1'b0;
      end

      if (state != IDLE) begin
        baud <= bit_end ? '0 : baud + CNT_W'(1);
      end

      case (state)
        IDLE: begin
          if (trigger) begin
            snap_r1  <= R1;
            snap_r2  <= R2;
            snap_r3  <= R3;
            ck       <= '0;
            byte_idx <= '0;
            bit_idx  <= '0;
            baud     <= '0;
            busy     <= 1'b1;
            tx       <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (bit_end) begin
            bit_idx <= '0;
            tx      <= cur_byte[0];
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_nxt;
              tx      <= cur_byte[bit_nxt];
            end
          end
        end
        STOP: begin
          // End of stop bit: chain straight into the next start bit or finish.
          if (bit_end) begin
            if (byte_idx != 3'd6) begin
              ck       <= ck ^ cur_byte;
              byte_idx <= byte_idx + 3'd1;
              tx       <= 1'b0;
              state    <= START;
            end else begin
              byte_idx <= '0;
              tx       <= 1'b1;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_result_uart.sv
// Scoreboard bench for mips_result_uart: stimulus queues expected UART bytes,
// per-instance decoders pop and compare each received frame.
`timescale 1ns/1ps
module tb_mips_result_uart;

  localparam int unsigned CPB_A = 4;
  localparam int unsigned CPB_B = 7;
  localparam logic [5:0]  DPC   = 6'd10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  pc_a = '0, pc_b = '0;
  logic [15:0] r1_a = '0, r2_a = '0, r3_a = '0;
  logic [15:0] r1_b = '0, r2_b = '0, r3_b = '0;
  logic        tx_a, busy_a, done_a, tx_b, busy_b, done_b;
  logic [1:0]  txs, busys;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt_a = 0;
  int done_cnt_b = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];

  assign txs   = {tx_b, tx_a};
  assign busys = {busy_b, busy_a};

  mips_result_uart #(.CLKS_PER_BIT(CPB_A), .PC_W(6), .DONE_PC(DPC)) dut_a (
    .clk(clk), .rst_n(rst_n), .PC(pc_a), .R1(r1_a), .R2(r2_a), .R3(r3_a),
    .tx(tx_a), .busy(busy_a), .done(done_a));

  mips_result_uart #(.CLKS_PER_BIT(CPB_B), .PC_W(6), .DONE_PC(DPC)) dut_b (
    .clk(clk), .rst_n(rst_n), .PC(pc_b), .R1(r1_b), .R2(r2_b), .R3(r3_b),
    .tx(tx_b), .busy(busy_b), .done(done_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Scoreboard side: pop the next expected byte for instance w and compare.
  task automatic sb_byte(input int w, input logic [7:0] got);
    logic [7:0] exp;
    if ((w == 0 && q_a.size() == 0) || (w == 1 && q_b.size() == 0)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_byte[%0d]: got %0h expected none", w, got);
    end else begin
      exp = (w == 0) ? q_a.pop_front() : q_b.pop_front();
      check($sformatf("uart_byte[%0d]", w), int'(got), int'(exp));
    end
  endtask

  task automatic wait_neg(input int n, inout bit ab);
    for (int k = 0; k < n && !ab; k++) begin
      @(negedge clk);
      if (!rst_n) ab = 1'b1;
    end
  endtask

  // UART receiver: mid-bit sampling, framing and start-to-start spacing checks.
  task automatic decode_loop(input int w, input int cpb);
    logic [7:0] b;
    bit         ab;
    int         nrep;
    int         last_start;
    nrep = 0;
    last_start = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        nrep = 0;
      end else if (txs[w[0]] == 1'b0) begin
        if (nrep > 0) check($sformatf("frame_spacing[%0d]", w), cyc - last_start, 10 * cpb);
        last_start = cyc;
        ab = 1'b0;
        b  = '0;
        wait_neg(cpb / 2, ab);
        if (!ab) check($sformatf("start_bit[%0d]", w), int'(txs[w[0]]), 0);
        for (int i = 0; i < 8 && !ab; i++) begin
          wait_neg(cpb, ab);
          b[i] = txs[w[0]];
        end
        if (!ab) wait_neg(cpb, ab);
        if (!ab) begin
          check($sformatf("stop_bit[%0d]", w), int'(txs[w[0]]), 1);
          sb_byte(w, b);
          nrep = (nrep == 6) ? 0 : nrep + 1;
        end else begin
          nrep = 0;
        end
      end
    end
  endtask

  task automatic push_exp(input int w, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [7:0] ck);
    logic [7:0] by[7];
    by[0] = a[15:8]; by[1] = a[7:0];
    by[2] = b[15:8]; by[3] = b[7:0];
    by[4] = c[15:8]; by[5] = c[7:0];
    by[6] = ck;
    for (int i = 0; i < 7; i++) begin
      if (w == 0) q_a.push_back(by[i]);
      else        q_b.push_back(by[i]);
    end
  endtask

  // Leave the halt address for one cycle, then present registers and PC=DONE_PC.
  task automatic arm_and_fire(input int w, input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] c, input logic [7:0] ck);
    @(negedge clk);
    if (w == 0) pc_a = 6'd0; else pc_b = 6'd0;
    @(negedge clk);
    if (w == 0) begin r1_a = a; r2_a = b; r3_a = c; pc_a = DPC; end
    else        begin r1_b = a; r2_b = b; r3_b = c; pc_b = DPC; end
    push_exp(w, a, b, c, ck);
  endtask

  // Counts busy-high samples until busy falls; bounded.
  task automatic wait_report(input int w, output int len);
    len = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (busys[w[0]]) len++;
      else if (len > 0) break;
    end
  endtask

  task automatic hold_idle(input int w, input int n, output int busy_seen);
    busy_seen = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (busys[w[0]]) busy_seen++;
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (done_a) done_cnt_a++;
    if (done_b) done_cnt_b++;
  end

  // Every tx run inside a report on instance B must be a whole number of bits.
  initial begin
    logic prev;
    int   last_tr;
    bit   valid;
    prev = 1'b1;
    last_tr = 0;
    valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!busy_b || !rst_n) valid = 1'b0;
      if (rst_n && tx_b != prev) begin
        if (busy_b && valid) check("bit_run_b", (cyc - last_tr) % int'(CPB_B), 0);
        last_tr = cyc;
        valid   = busy_b;
      end
      prev = tx_b;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int len;
    int d0;
    int seen;
    fork
      decode_loop(0, int'(CPB_A));
      decode_loop(1, int'(CPB_B));
    join_none

    // Reset and idle
    repeat (3) @(negedge clk);
    check("rst_tx_a", int'(tx_a), 1);
    check("rst_busy_a", int'(busy_a), 0);
    check("rst_done_a", int'(done_a), 0);
    check("rst_tx_b", int'(tx_b), 1);
    rst_n = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      check("idle_tx", int'(tx_a), 1);
      check("idle_busy", int'(busy_a), 0);
      check("idle_done", int'(done_a), 0);
    end

    // Basic report: 00 03 00 05 00 0F 09
    d0 = done_cnt_a;
    arm_and_fire(0, 16'h0003, 16'h0005, 16'h000F, 8'h09);
    wait_report(0, len);
    check("basic_len", len, 280);
    repeat (5) @(negedge clk);
    check("basic_done", done_cnt_a - d0, 1);
    hold_idle(0, 100, seen);
    check("basic_no_repeat", seen, 0);
    check("basic_q_empty", q_a.size(), 0);

    // Snapshot isolation: inputs zeroed right after the trigger edge
    arm_and_fire(0, 16'hABCD, 16'h1234, 16'hFFFF, 8'h40);
    @(negedge clk);
    check("snap_busy_rise", int'(busy_a), 1);
    r1_a = '0; r2_a = '0; r3_a = '0;
    wait_report(0, len);
    check("snap_len", len + 1, 280);
    repeat (5) @(negedge clk);
    check("snap_q_empty", q_a.size(), 0);

    // Re-arm during busy: second report on the first IDLE edge
    d0 = done_cnt_a;
    arm_and_fire(0, 16'h1234, 16'h5678, 16'h9ABC, 8'h2E);
    push_exp(0, 16'h1234, 16'h5678, 16'h9ABC, 8'h2E);
    repeat (20) @(negedge clk);
    pc_a = 6'd11;
    @(negedge clk);
    pc_a = DPC;
    wait_report(0, len);
    @(negedge clk);
    check("rearm_restart", int'(busy_a), 1);
    wait_report(0, len);
    check("rearm_len", len + 1, 280);
    hold_idle(0, 100, seen);
    check("rearm_no_third", seen, 0);
    check("rearm_done", done_cnt_a - d0, 2);
    check("rearm_q_empty", q_a.size(), 0);

    // Reset mid-report, during the data bits of byte 3
    arm_and_fire(0, 16'h0102, 16'h0408, 16'h1020, 8'h3F);
    repeat (136) @(negedge clk);
    #2;
    rst_n = 1'b0;
    q_a.delete();
    #1;
    check("midrst_tx", int'(tx_a), 1);
    check("midrst_busy", int'(busy_a), 0);
    repeat (3) @(negedge clk);
    d0 = done_cnt_a;
    push_exp(0, 16'h0102, 16'h0408, 16'h1020, 8'h3F);
    rst_n = 1'b1;
    wait_report(0, len);
    check("midrst_fresh_len", len, 280);
    repeat (5) @(negedge clk);
    check("midrst_done", done_cnt_a - d0, 1);
    check("midrst_q_empty", q_a.size(), 0);

    // Bit timing at CLKS_PER_BIT=7
    d0 = done_cnt_b;
    arm_and_fire(1, 16'h8001, 16'h4002, 16'hC3A5, 8'hA5);
    wait_report(1, len);
    check("b_len", len, 490);
    repeat (10) @(negedge clk);
    check("b_done", done_cnt_b - d0, 1);
    check("b_q_empty", q_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
